// File: rtl/window_buffer_3x3_pkg.sv
// Shared definitions for the 3x3 window generator and the downstream
// gaussian_operator, so both agree on kernel size and packing order.
package window_buffer_3x3_pkg;

  localparam int KERNEL_DIM = 3;

  // Width of a packed 3x3 kernel bus for a given pixel width.
  function automatic int KERNEL_WIDTH(input int dw);
    return KERNEL_DIM * KERNEL_DIM * dw;
  endfunction

  // Slot of window element (row, col) in the packed kernel; row 0 is the
  // oldest line, col 0 the oldest column, slot 4 the centre.
  function automatic int kernel_idx(input int row, input int col);
    return KERNEL_DIM * row + col;
  endfunction

endpackage

// File: rtl/window_buffer_3x3_line_buffer.sv
// One image line of pixel storage: combinational read of the addressed
// column, synchronous write on the same column. A read in the cycle of a
// write returns the old contents. Contents are not reset.
module line_buffer #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 640,
  parameter int ADDR_W     = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  assign rdata = mem_q[addr];

  // Write the addressed column when enabled.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end
  end

endmodule

// File: rtl/window_buffer_3x3.sv
// Streaming 3x3 window generator: raster pixels in, one packed 3x3
// neighbourhood out for every pixel whose window lies fully inside the image.
module window_buffer_3x3
  import window_buffer_3x3_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [DATA_WIDTH-1:0]                 data_in,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [KERNEL_WIDTH(DATA_WIDTH)-1:0]   kernel
);

  localparam int COL_W = $clog2(IMG_WIDTH);
  localparam int ROW_W = $clog2(IMG_HEIGHT);
  localparam int KW    = KERNEL_WIDTH(DATA_WIDTH);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);

  logic [COL_W-1:0]      col_q, col_d;
  logic [ROW_W-1:0]      row_q, row_d;
  logic [DATA_WIDTH-1:0] win_q [KERNEL_DIM][KERNEL_DIM];
  logic [DATA_WIDTH-1:0] win_d [KERNEL_DIM][KERNEL_DIM];
  logic [KW-1:0]         kernel_q, kernel_d;
  logic                  out_valid_q, out_valid_d;

  logic                  accept;
  logic                  emit;
  logic [DATA_WIDTH-1:0] top_rd, mid_rd;

  assign in_ready  = !out_valid_q || out_ready;
  assign accept    = in_valid && in_ready;
  assign emit      = (row_q >= ROW_W'(2)) && (col_q >= COL_W'(2));
  assign out_valid = out_valid_q;
  assign kernel    = kernel_q;

  // Oldest buffered line: receives the middle line's old pixel.
  line_buffer #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (IMG_WIDTH),
    .ADDR_W     (COL_W)
  ) lb_top (
    .clk   (clk),
    .we    (accept),
    .addr  (col_q),
    .wdata (mid_rd),
    .rdata (top_rd)
  );

  // Previous line: receives the incoming pixel.
  line_buffer #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (IMG_WIDTH),
    .ADDR_W     (COL_W)
  ) lb_mid (
    .clk   (clk),
    .we    (accept),
    .addr  (col_q),
    .wdata (data_in),
    .rdata (mid_rd)
  );

  // Raster position of the next pixel; wraps per line and per frame.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (accept) begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + ROW_W'(1);
      end else begin
        col_d = col_q + COL_W'(1);
      end
    end
  end

  // Shift the window left and insert the new column on every accept.
  always_comb begin
    win_d = win_q;
    if (accept) begin
      for (int r = 0; r < KERNEL_DIM; r++) begin
        for (int c = 0; c < KERNEL_DIM - 1; c++) begin
          win_d[r][c] = win_q[r][c+1];
        end
      end
      win_d[0][KERNEL_DIM-1] = top_rd;
      win_d[1][KERNEL_DIM-1] = mid_rd;
      win_d[2][KERNEL_DIM-1] = data_in;
    end
  end

  // Output register: load a fresh window on an emitting accept, else drain.
  always_comb begin
    kernel_d    = kernel_q;
    out_valid_d = out_valid_q;
    if (accept && emit) begin
      for (int r = 0; r < KERNEL_DIM; r++) begin
        for (int c = 0; c < KERNEL_DIM; c++) begin
          kernel_d[kernel_idx(r, c)*DATA_WIDTH +: DATA_WIDTH] = win_d[r][c];
        end
      end
      out_valid_d = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // State registers; reset starts a new frame and drops any pending window.
  always_ff @(posedge clk) begin
    if (rst) begin
      col_q       <= '0;
      row_q       <= '0;
      win_q       <= '{default: '0};
      kernel_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      win_q       <= win_d;
      kernel_q    <= kernel_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_window_buffer_3x3.sv
// Bench for window_buffer_3x3 on a small 5x4 image: ramp and random images,
// random handshake pressure, stalls and mid-frame reset, scored against
// windows computed directly from the image.
module tb_window_buffer_3x3;

  localparam int DW = 8;
  localparam int W  = 5;
  localparam int H  = 4;
  localparam int N  = W * H;
  localparam int KW = 9 * DW;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] data_in;
  logic          out_valid;
  logic          out_ready;
  logic [KW-1:0] kernel;

  window_buffer_3x3 #(
    .DATA_WIDTH (DW),
    .IMG_WIDTH  (W),
    .IMG_HEIGHT (H)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_in   (data_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .kernel    (kernel)
  );

  always #5 clk = ~clk;

  int            n_cmp = 0;
  int            n_bad = 0;
  int            n_win = 0;
  logic [KW-1:0] exp_q [$];
  logic [DW-1:0] img [N];
  logic          prev_stall = 1'b0;
  logic [KW-1:0] prev_k = '0;

  task automatic chk(input string tag, input logic [KW-1:0] got, input logic [KW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic load_ramp();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        img[r*W+c] = DW'(16 * r + c);
  endtask

  task automatic load_rand();
    for (int p = 0; p < N; p++) img[p] = DW'($urandom);
  endtask

  // Every window whose bottom-right pixel is at row>=2, col>=2, in raster order.
  task automatic queue_windows();
    logic [KW-1:0] k;
    for (int r = 2; r < H; r++)
      for (int c = 2; c < W; c++) begin
        k = '0;
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++)
            k[(3*i+j)*DW +: DW] = img[(r-2+i)*W + (c-2+j)];
        exp_q.push_back(k);
      end
  endtask

  // Offer one pixel until accepted; called and returns at posedge+1.
  task automatic send_pix(input logic [DW-1:0] p, input bit rnd);
    int  guard;
    bit  acc;
    if (rnd) begin
      while ($urandom_range(0, 2) == 0) begin
        in_valid  = 1'b0;
        out_ready = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
      end
    end
    guard = 0;
    acc   = 1'b0;
    while (!acc && guard < 1000) begin
      in_valid  = 1'b1;
      data_in   = p;
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
      guard++;
    end
    in_valid = 1'b0;
    if (!acc) chk("accept_timeout", 0, 1);
  endtask

  task automatic send_frame(input bit rnd, input bit lat_chk, input bit stall);
    for (int p = 0; p < N; p++) begin
      send_pix(img[p], rnd);
      if (lat_chk && p == 2*W + 2) begin
        out_ready = 1'b0;
        @(negedge clk);
        chk("lat_vld", KW'(out_valid), 1);
        chk("lat_kernel", kernel, 72'h222120121110020100);
        @(posedge clk); #1;
      end
      if (stall && p == 2*W + 2) begin
        in_valid  = 1'b1;
        data_in   = img[p+1];
        out_ready = 1'b0;
        for (int s = 0; s < 10; s++) begin
          @(negedge clk);
          chk("stall_in_ready", KW'(in_ready), 0);
          @(posedge clk); #1;
        end
        in_valid = 1'b0;
      end
    end
  endtask

  task automatic drain_and_count(input string tag, input int exp_n);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (4) begin @(posedge clk); #1; end
    chk(tag, KW'(n_win), KW'(exp_n));
    chk({tag, "_left"}, KW'(exp_q.size()), 0);
  endtask

  // Scoreboard: every output transfer must match the next expected window,
  // and a stalled output must hold.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_vld", KW'(out_valid), 1);
        chk("hold_kernel", kernel, prev_k);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("extra_window", kernel, '0 - 1);
        else chk("window", kernel, exp_q.pop_front());
        n_win++;
      end
      prev_stall = out_valid && !out_ready;
      prev_k     = kernel;
    end
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; data_in = '0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_vld", KW'(out_valid), 0);
    chk("rst_kernel", kernel, '0);
    chk("rst_in_ready", KW'(in_ready), 1);
    @(posedge clk); #1;
    rst = 1'b0;

    // continuous ramp frame
    load_ramp(); queue_windows();
    send_frame(1'b0, 1'b1, 1'b0);
    drain_and_count("ramp_count", 6);

    // two back-to-back ramp frames
    n_win = 0;
    queue_windows(); send_frame(1'b0, 1'b0, 1'b0);
    queue_windows(); send_frame(1'b0, 1'b0, 1'b0);
    drain_and_count("b2b_count", 12);

    // ramp and random images under random gaps and backpressure
    n_win = 0;
    queue_windows(); send_frame(1'b1, 1'b0, 1'b0);
    for (int f = 0; f < 4; f++) begin
      load_rand(); queue_windows(); send_frame(1'b1, 1'b0, 1'b0);
    end
    drain_and_count("rand_count", 30);

    // long output stall with a pixel offered
    n_win = 0;
    load_ramp(); queue_windows();
    send_frame(1'b0, 1'b0, 1'b1);
    drain_and_count("stall_count", 6);

    // reset after seven pixels, then restart the ramp
    n_win = 0;
    for (int p = 0; p < 7; p++) send_pix(img[p], 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst2_vld", KW'(out_valid), 0);
    chk("rst2_kernel", kernel, '0);
    chk("rst2_in_ready", KW'(in_ready), 1);
    @(posedge clk); #1;
    queue_windows();
    send_frame(1'b0, 1'b1, 1'b0);
    drain_and_count("rst_count", 6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
